v_rx_scoreboard_queue: RTL



---
 rtl/v_noc_pkg.sv | 17 +
 rtl/v_sync_fifo.sv | 56 +++++
 rtl/v_rx_scoreboard_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/v_noc_pkg.sv
// Shared NoC testbench-side types: node ids, receiver check records and
// the default depth of the receiver-to-scoreboard queue.
package v_noc_pkg;

  localparam int V_RX_QUEUE_DEPTH = 8;
  localparam int NODE_ID_W        = 4;

  typedef logic [NODE_ID_W-1:0] node_id_t;

  typedef struct packed {
    logic [7:0]  rec_id;
    node_id_t    src_id;
    logic [7:0]  txn_id;
    logic [31:0] flit_data;
  } receiver_info_t;

endpackage

// File: rtl/v_sync_fifo.sv
// Single-clock circular-buffer FIFO with explicit pointer wrap, so DEPTH
// need not be a power of two. The caller guarantees no write when full
// without a same-cycle read, and no read when empty.
module v_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage carries no reset; validity is tracked by count alone,
  // and a resettable array would cost a flop-based memory for no benefit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every sequential state element uses non-blocking assignment so
  // all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (rd_en) rd_ptr <= bump(rd_ptr);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (rd_en && !wr_en) count <= count - CNT_W'(1);
    end
  end

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/v_rx_scoreboard_queue.sv
// Elastic buffer from a no-backpressure flit receiver to the scoreboard,
// with traffic statistics and a sticky overflow flag for end-of-test checks.
module v_rx_scoreboard_queue
  import v_noc_pkg::*;
#(
  parameter int DEPTH  = V_RX_QUEUE_DEPTH,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_vld_i,
  input  receiver_info_t      enq_info_i,
  output logic                deq_vld_o,
  output receiver_info_t      deq_info_o,
  input  logic                deq_rdy_i,
  input  logic                clear_stats_i,
  output logic [OCC_W-1:0]    occupancy_o,
  output logic [OCC_W-1:0]    max_occ_o,
  output logic [CNT_W-1:0]    rx_cnt_o,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                overflow_o
);

  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int INFO_W = $bits(receiver_info_t);

  logic              full;
  logic              empty;
  logic [FCNT_W-1:0] count;
  logic [INFO_W-1:0] head;
  logic              enq;
  logic              deq;
  logic              drop;
  logic [FCNT_W-1:0] next_count;

  v_sync_fifo #(
    .WIDTH (INFO_W),
    .DEPTH (DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data (enq_info_i),
    .rd_en   (deq),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    deq        = 1'b0;
    enq        = 1'b0;
    drop       = 1'b0;
    deq_vld_o  = !empty;
    deq_info_o = '0;
    if (!empty) deq_info_o = receiver_info_t'(head);
    deq        = deq_vld_o && deq_rdy_i;
    // A full queue still accepts when the head leaves in the same cycle.
    enq        = enq_vld_i && (!full || deq);
    drop       = enq_vld_i && full && !deq;
    next_count = count + FCNT_W'(enq) - FCNT_W'(deq);
  end

  assign occupancy_o = OCC_W'(count);

  // Clear outranks any same-cycle event; the FIFO itself is untouched.
  always_ff @(posedge clk) begin
    if (rst || clear_stats_i) begin
      rx_cnt_o   <= '0;
      drop_cnt_o <= '0;
      max_occ_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (enq) rx_cnt_o <= rx_cnt_o + CNT_W'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
      end
      if (OCC_W'(next_count) > max_occ_o) max_occ_o <= OCC_W'(next_count);
    end
  end

endmodule
